seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's hex-to-7-segment encoder.
- Watches NDIG active-low 7-segment patterns, e.g. the HEX0..HEX7 drive bus on DE2-115. Waits until the bus is stable, then decodes each pattern back to a hex nibble, one digit per cycle.
- Presents the word with blank/illegal flags over a valid/ready handshake.
- Used for self-check of display paths and for loopback of display state into logic analysers or UART dumps.

---
 rtl/seg7_scan_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Watches an active-low multi-digit 7-segment bus, waits for it to
//            settle, decodes each digit back to a hex nibble (one digit per
//            cycle) and presents the word with blank/illegal flags over a
//            valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NDIG          = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7*NDIG-1:0]   seg_in,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     blank,
    output logic [NDIG-1:0]     illegal,
    output logic                err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0] C_IDX_LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [7*NDIG-1:0]   r_seg_q;
    logic [CW-1:0]       r_cnt;
    logic [7*NDIG-1:0]   r_snap;
    logic [7*NDIG-1:0]   r_last_word;
    logic                r_have_reported;
    logic [IW-1:0]       r_idx;

    logic [4*NDIG-1:0]   r_sh_value;
    logic [NDIG-1:0]     r_sh_blank;
    logic [NDIG-1:0]     r_sh_illegal;
    logic [4*NDIG-1:0]   w_sh_value;
    logic [NDIG-1:0]     w_sh_blank;
    logic [NDIG-1:0]     w_sh_illegal;

    logic                w_stable;
    logic                w_trigger;
    logic                w_capture;
    logic                w_last;
    logic                w_accept;
    logic [6:0]          w_dig;
    logic [5:0]          w_dec;

    // Returns {illegal, blank, nibble} for one active-low glyph.
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] r;
        r = 6'b10_0000;
        case (p)
            7'h40: r = 6'h00;
            7'h79: r = 6'h01;
            7'h24: r = 6'h02;
            7'h30: r = 6'h03;
            7'h19: r = 6'h04;
            7'h12: r = 6'h05;
            7'h02: r = 6'h06;
            7'h78: r = 6'h07;
            7'h00: r = 6'h08;
            7'h10: r = 6'h09;
            7'h08: r = 6'h0A;
            7'h03: r = 6'h0B;
            7'h46: r = 6'h0C;
            7'h21: r = 6'h0D;
            7'h06: r = 6'h0E;
            7'h0E: r = 6'h0F;
            7'h7F: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    assign w_stable  = (r_cnt == C_CNT_MAX);
    assign w_trigger = (r_state == S_IDLE) && w_stable &&
                       (!r_have_reported || (r_seg_q != r_last_word));
    assign busy      = (r_state != S_IDLE);

    // Stability filter: resample the bus and count consecutive identical samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_q <= '0;
            r_cnt   <= '0;
        end else begin
            r_seg_q <= seg_in;
            if (seg_in != r_seg_q) begin
                r_cnt <= '0;
            end else if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Select the snapshot digit currently being scanned and decode it.
    always_comb begin
        w_dig = 7'h7F;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_dig = r_snap[7*i +: 7];
            end
        end
        w_dec = f_decode(w_dig);
    end

    // Merge the freshly decoded digit into the shadow result word.
    always_comb begin
        w_sh_value   = r_sh_value;
        w_sh_blank   = r_sh_blank;
        w_sh_illegal = r_sh_illegal;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_sh_value[4*i +: 4] = w_dec[3:0];
                w_sh_blank[i]        = w_dec[4];
                w_sh_illegal[i]      = w_dec[5];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_last       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_idx == C_IDX_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: snapshot, digit scan into shadows, publish on the last digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap          <= '0;
            r_idx           <= '0;
            r_sh_value      <= '0;
            r_sh_blank      <= '0;
            r_sh_illegal    <= '0;
            r_last_word     <= '0;
            r_have_reported <= 1'b0;
            value           <= '0;
            blank           <= '0;
            illegal         <= '0;
            err             <= 1'b0;
            out_valid       <= 1'b0;
        end else begin
            if (w_capture) begin
                r_snap <= r_seg_q;
                r_idx  <= '0;
            end
            if (r_state == S_SCAN) begin
                r_sh_value   <= w_sh_value;
                r_sh_blank   <= w_sh_blank;
                r_sh_illegal <= w_sh_illegal;
                if (!w_last) begin
                    r_idx <= r_idx + IW'(1);
                end
            end
            // The last digit goes straight from the merge into the outputs.
            if (w_last) begin
                value           <= w_sh_value;
                blank           <= w_sh_blank;
                illegal         <= w_sh_illegal;
                err             <= |w_sh_illegal;
                r_last_word     <= r_snap;
                r_have_reported <= 1'b1;
                out_valid       <= 1'b1;
            end
            if (w_accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Purpose  : Directed self-checking bench for seg7_scan_decoder (NDIG=8,
//            STABLE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [55:0] seg_in;
    logic [31:0] value;
    logic [7:0]  blank;
    logic [7:0]  illegal;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    seg7_scan_decoder #(
        .NDIG          (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .value     (value),
        .blank     (blank),
        .illegal   (illegal),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table, active-low, bit0 = segment a.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] pack(input logic [31:0] w);
        logic [55:0] s;
        for (int i = 0; i < 8; i++) s[7*i +: 7] = glyph(w[4*i +: 4]);
        return s;
    endfunction

    // Waits (bounded) for out_valid; lat = number of negedges waited.
    task automatic wait_pulse(input int max, output bit found, output int lat);
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                lat   = k;
                break;
            end
        end
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        seg_in    = '0;
        repeat (3) @(negedge clk);
        checks++; if (value !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=%h", value, 32'h0); end
        checks++; if (blank !== 8'h0 || illegal !== 8'h0) begin failures++; $display("FAIL reset_flags got=%h/%h exp=00/00", blank, illegal); end
        checks++; if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctrl got err=%b vld=%b busy=%b exp=0/0/0", err, out_valid, busy); end
    endtask

    // First word after reset: the edge after release samples the new bus (E);
    // out_valid is registered at E+12 and seen at the 13th negedge.
    task automatic test_first_word;
        bit found; int lat; int cnt;
        rst_n  = 1'b1;
        seg_in = pack(32'h01234567);
        wait_pulse(40, found, lat);
        checks++; if (!found || lat != 13) begin failures++; $display("FAIL t1_latency got found=%0d lat=%0d exp lat=13", found, lat); end
        checks++; if (value !== 32'h01234567) begin failures++; $display("FAIL t1_value got=%h exp=%h", value, 32'h01234567); end
        checks++; if (blank !== 8'h00 || illegal !== 8'h00 || err !== 1'b0) begin failures++; $display("FAIL t1_flags got b=%h i=%h e=%b exp 00/00/0", blank, illegal, err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t1_pulse_width got=%b exp=0", out_valid); end
        count_valid(40, cnt);
        checks++; if (cnt != 0) begin failures++; $display("FAIL t1_no_rereport got=%0d exp=0", cnt); end
    endtask

    task automatic test_glyphs;
        bit found; int lat; int cnt;
        logic [31:0] words [2];
        words[0] = 32'h89ABCDEF;
        words[1] = 32'h01234567;
        for (int w = 0; w < 2; w++) begin
            seg_in = pack(words[w]);
            wait_pulse(40, found, lat);
            checks++; if (!found || value !== words[w]) begin failures++; $display("FAIL t2_value[%0d] got=%h found=%0d exp=%h", w, value, found, words[w]); end
            count_valid(25, cnt);
            checks++; if (cnt != 0) begin failures++; $display("FAIL t2_single_pulse[%0d] got extra=%0d exp=0", w, cnt); end
        end
    endtask

    task automatic test_blank_illegal;
        bit found; int lat;
        logic [55:0] s;
        s = pack(32'h01234567);
        s[21 +: 7] = 7'h7F;
        s[35 +: 7] = 7'h7E;
        seg_in = s;
        wait_pulse(40, found, lat);
        checks++; if (!found || value !== 32'h01030567) begin failures++; $display("FAIL t3_value got=%h found=%0d exp=%h", value, found, 32'h01030567); end
        checks++; if (blank !== 8'h08) begin failures++; $display("FAIL t3_blank got=%h exp=08", blank); end
        checks++; if (illegal !== 8'h20) begin failures++; $display("FAIL t3_illegal got=%h exp=20", illegal); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL t3_err got=%b exp=1", err); end
    endtask

    task automatic test_glitch;
        bit found; int lat; int cnt;
        seg_in = pack(32'h00000000);
        wait_pulse(40, found, lat);
        checks++; if (!found || value !== 32'h0) begin failures++; $display("FAIL t4_base got=%h found=%0d exp=00000000", value, found); end
        repeat (3) @(negedge clk);
        // three-sample glitch on digit 0, then back to the reported word
        seg_in = pack(32'h00000001);
        repeat (3) @(negedge clk);
        seg_in = pack(32'h00000000);
        count_valid(30, cnt);
        checks++; if (cnt != 0) begin failures++; $display("FAIL t4_glitch_rejected got pulses=%0d exp=0", cnt); end
        seg_in = pack(32'h00000001);
        wait_pulse(40, found, lat);
        checks++; if (!found || lat != 13) begin failures++; $display("FAIL t4_latency got found=%0d lat=%0d exp lat=13", found, lat); end
        checks++; if (value !== 32'h00000001) begin failures++; $display("FAIL t4_value got=%h exp=00000001", value); end
        count_valid(20, cnt);
        checks++; if (cnt != 0) begin failures++; $display("FAIL t4_single_pulse got extra=%0d exp=0", cnt); end
    endtask

    task automatic test_backpressure;
        bit found; int lat; int cnt;
        out_ready = 1'b0;
        seg_in    = pack(32'hDEADBEEF);
        wait_pulse(40, found, lat);
        checks++; if (!found || value !== 32'hDEADBEEF) begin failures++; $display("FAIL t5_x_value got=%h found=%0d exp=deadbeef", value, found); end
        seg_in = pack(32'h12345678);
        repeat (20) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || value !== 32'hDEADBEEF) begin failures++; $display("FAIL t5_hold_y got vld=%b val=%h exp 1/deadbeef", out_valid, value); end
        seg_in = pack(32'hCAFEF00D);
        repeat (20) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || value !== 32'hDEADBEEF || busy !== 1'b1) begin failures++; $display("FAIL t5_hold_z got vld=%b val=%h busy=%b exp 1/deadbeef/1", out_valid, value, busy); end
        // accept edge -> IDLE, next edge triggers on the stable Z, 8 scan edges
        out_ready = 1'b1;
        wait_pulse(40, found, lat);
        checks++; if (!found || lat != 10) begin failures++; $display("FAIL t5_release_latency got found=%0d lat=%0d exp lat=10", found, lat); end
        checks++; if (value !== 32'hCAFEF00D) begin failures++; $display("FAIL t5_z_value got=%h exp=cafef00d", value); end
        count_valid(40, cnt);
        checks++; if (cnt != 0) begin failures++; $display("FAIL t5_y_dropped got pulses=%0d exp=0", cnt); end
    endtask

    task automatic test_reset_mid_scan;
        bit found; int lat;
        seg_in = pack(32'h76543210);
        // edges E..E+3 filter, E+4 capture, E+5 first scan step
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL t6_in_scan got busy=%b vld=%b exp 1/0", busy, out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (value !== 32'h0 || blank !== 8'h0 || illegal !== 8'h0 || err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL t6_reset_outputs got val=%h b=%h i=%h e=%b v=%b busy=%b exp all 0", value, blank, illegal, err, out_valid, busy);
        end
        rst_n = 1'b1;
        wait_pulse(40, found, lat);
        checks++; if (!found || lat != 13) begin failures++; $display("FAIL t6_rereport_latency got found=%0d lat=%0d exp lat=13", found, lat); end
        checks++; if (value !== 32'h76543210) begin failures++; $display("FAIL t6_value got=%h exp=76543210", value); end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        seg_in    = '0;
        test_reset;
        test_first_word;
        test_glyphs;
        test_blank_illegal;
        test_glitch;
        test_backpressure;
        test_reset_mid_scan;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
